// File: rtl/reservation_station_nx_forward.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_nx_forward
// Purpose  : N-entry reservation station for one execution unit. Accepts
//            renamed ops from decode, snoops the commit / exec / memory result
//            buses for missing source operands and issues the oldest ready
//            entry to the unit's issue stage.
// Ports    : clk_i, reset_i           - clock, synchronous active-high reset
//            flush_i                  - (RS_FLUSH_EN only) drop every entry
//            decode*_i / stall_o      - allocation side, stall_o = all busy
//            issueROB*_i              - commit, exec and memory result buses
//            stall_i                  - issue stage cannot accept
//            reservationStation*_o    - issued operands, command, dest tag
//            ready_o                  - an issuable entry is presented
// Options  : define RS_FLUSH_EN to add the flush_i input.
// Revision : 1.0 - initial release
// ============================================================================
module reservation_station_nx_forward #(
    parameter int ENTRIES    = 4,
    parameter int DATA_W     = 64,
    parameter int CMD_W      = 10,
    parameter int ROBsize    = 16,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
`ifdef RS_FLUSH_EN
    input  logic                  flush_i,
`endif
    input  logic                  decodeWriteEn_i,
    input  logic [ROBsizeLog-1:0] decodeROBTag_i,
    input  logic [ROBsizeLog-1:0] decodeROBTag1_i,
    input  logic [ROBsizeLog-1:0] decodeROBTag2_i,
    input  logic [DATA_W:0]       decodeROBval1_i,
    input  logic [DATA_W:0]       decodeROBval2_i,
    input  logic [CMD_W-1:0]      decodeCommands_i,
    output logic                  stall_o,
    input  logic [ROBsizeLog-1:0] issueROBTagCom_i,
    input  logic [DATA_W:0]       issueROBvalCom_i,
    input  logic [ROBsizeLog-1:0] issueROBTagExec_i,
    input  logic [DATA_W:0]       issueROBvalExec_i,
    input  logic                  issueROBMemAccessExec_i,
    input  logic [ROBsizeLog-1:0] issueROBTagMem_i,
    input  logic [DATA_W:0]       issueROBvalMem_i,
    input  logic                  stall_i,
    output logic [DATA_W-1:0]     reservationStationVal1_o,
    output logic [DATA_W-1:0]     reservationStationVal2_o,
    output logic [CMD_W-1:0]      reservationStationCommands_o,
    output logic [ROBsizeLog-1:0] reservationStationTag_o,
    output logic                  ready_o
);

    localparam int c_IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Entry state. Operand words keep the valid flag in the MSB.
    logic [ENTRIES-1:0]    r_busy;
    // r_age[i][j] = 1 : entry j is older than entry i
    logic [ENTRIES-1:0]    r_age  [ENTRIES];
    logic [CMD_W-1:0]      r_cmd  [ENTRIES];
    logic [ROBsizeLog-1:0] r_dst  [ENTRIES];
    logic [ROBsizeLog-1:0] r_tag1 [ENTRIES];
    logic [ROBsizeLog-1:0] r_tag2 [ENTRIES];
    logic [DATA_W:0]       r_op1  [ENTRIES];
    logic [DATA_W:0]       r_op2  [ENTRIES];

    logic                  w_flush;
    logic                  w_alloc;
    logic                  w_issue;
    logic [c_IDX_W-1:0]    w_alloc_idx;
    logic [ENTRIES-1:0]    w_ready;
    logic [ENTRIES-1:0]    w_grant;
    logic [DATA_W:0]       w_op1_nxt [ENTRIES];
    logic [DATA_W:0]       w_op2_nxt [ENTRIES];
    logic [DATA_W:0]       w_dec_op1;
    logic [DATA_W:0]       w_dec_op2;

`ifdef RS_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    // Operand capture with bus priority Exec > Mem > Com. An exec result that
    // is a memory address is not an operand value and is never forwarded.
    function automatic logic [DATA_W:0] f_forward(input logic [DATA_W:0]       cur,
                                                  input logic [ROBsizeLog-1:0] tag);
        logic [DATA_W:0] res;
        res = cur;
        if (!cur[DATA_W]) begin
            if (issueROBvalExec_i[DATA_W] && !issueROBMemAccessExec_i &&
                (issueROBTagExec_i == tag))
                res = issueROBvalExec_i;
            else if (issueROBvalMem_i[DATA_W] && (issueROBTagMem_i == tag))
                res = issueROBvalMem_i;
            else if (issueROBvalCom_i[DATA_W] && (issueROBTagCom_i == tag))
                res = issueROBvalCom_i;
        end
        return res;
    endfunction

    assign stall_o   = &r_busy;
    assign w_alloc   = decodeWriteEn_i & ~stall_o & ~w_flush;
    assign ready_o   = |w_grant;
    assign w_issue   = ready_o & ~stall_i;
    assign w_dec_op1 = f_forward(decodeROBval1_i, decodeROBTag1_i);
    assign w_dec_op2 = f_forward(decodeROBval2_i, decodeROBTag2_i);

    // Lowest-index free entry.
    always_comb begin
        w_alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_alloc_idx = c_IDX_W'(i);
        end
    end

    // An entry is granted when it is ready and no older entry is ready.
    generate
        for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
            assign w_ready[g]   = r_busy[g] & r_op1[g][DATA_W] & r_op2[g][DATA_W];
            assign w_grant[g]   = w_ready[g] & ~(|(w_ready & r_age[g])) & ~w_flush;
            assign w_op1_nxt[g] = f_forward(r_op1[g], r_tag1[g]);
            assign w_op2_nxt[g] = f_forward(r_op2[g], r_tag2[g]);
        end
    endgenerate

    // Grant is one-hot or zero, so an AND-OR mux yields all-zero when idle.
    always_comb begin
        reservationStationVal1_o     = '0;
        reservationStationVal2_o     = '0;
        reservationStationCommands_o = '0;
        reservationStationTag_o      = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            reservationStationVal1_o     |= {DATA_W{w_grant[i]}} & r_op1[i][DATA_W-1:0];
            reservationStationVal2_o     |= {DATA_W{w_grant[i]}} & r_op2[i][DATA_W-1:0];
            reservationStationCommands_o |= {CMD_W{w_grant[i]}} & r_cmd[i];
            reservationStationTag_o      |= {ROBsizeLog{w_grant[i]}} & r_dst[i];
        end
    end

    // Control state: busy bits and age matrix. A new entry is younger than
    // every busy entry; its column is cleared so stale "older" marks left by
    // the slot's previous occupant disappear.
    always_ff @(posedge clk_i) begin
        if (reset_i || w_flush) begin
            r_busy <= '0;
            for (int i = 0; i < ENTRIES; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_alloc && (w_alloc_idx == c_IDX_W'(i)))
                    r_busy[i] <= 1'b1;
                else if (w_issue && w_grant[i])
                    r_busy[i] <= 1'b0;
                for (int j = 0; j < ENTRIES; j++) begin
                    if (w_alloc) begin
                        if (w_alloc_idx == c_IDX_W'(i))
                            r_age[i][j] <= r_busy[j] && (i != j);
                        else if (w_alloc_idx == c_IDX_W'(j))
                            r_age[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // Payload carries no reset: every use is qualified by the busy bit.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_alloc && (w_alloc_idx == c_IDX_W'(i))) begin
                r_cmd[i]  <= decodeCommands_i;
                r_dst[i]  <= decodeROBTag_i;
                r_tag1[i] <= decodeROBTag1_i;
                r_tag2[i] <= decodeROBTag2_i;
                r_op1[i]  <= w_dec_op1;
                r_op2[i]  <= w_dec_op2;
            end else begin
                r_op1[i]  <= w_op1_nxt[i];
                r_op2[i]  <= w_op2_nxt[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station_nx_forward.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station_nx_forward
// Purpose  : Self-checking bench for reservation_station_nx_forward. Directed
//            scenarios followed by randomized traffic; a queue-based age-ordered
//            reference model predicts issues into a scoreboard that a
//            separate monitor drains whenever the DUT issues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reservation_station_nx_forward;

    localparam int ENTRIES = 4;
    localparam int DATA_W  = 64;
    localparam int CMD_W   = 10;
    localparam int TW      = 5;

    logic              clk = 1'b0;
    logic              r_reset;
    logic              r_we;
    logic [TW-1:0]     r_dtag, r_dt1, r_dt2;
    logic [DATA_W:0]   r_dv1, r_dv2;
    logic [CMD_W-1:0]  r_dcmd;
    logic [TW-1:0]     r_tcom, r_texec, r_tmem;
    logic [DATA_W:0]   r_vcom, r_vexec, r_vmem;
    logic              r_memacc;
    logic              r_stall_i;
    logic              w_stall_o;
    logic [DATA_W-1:0] w_v1, w_v2;
    logic [CMD_W-1:0]  w_cmd;
    logic [TW-1:0]     w_tag;
    logic              w_ready;

    always #5 clk = ~clk;

    reservation_station_nx_forward dut (
        .clk_i                        (clk),
        .reset_i                      (r_reset),
`ifdef RS_FLUSH_EN
        .flush_i                      (1'b0),
`endif
        .decodeWriteEn_i              (r_we),
        .decodeROBTag_i               (r_dtag),
        .decodeROBTag1_i              (r_dt1),
        .decodeROBTag2_i              (r_dt2),
        .decodeROBval1_i              (r_dv1),
        .decodeROBval2_i              (r_dv2),
        .decodeCommands_i             (r_dcmd),
        .stall_o                      (w_stall_o),
        .issueROBTagCom_i             (r_tcom),
        .issueROBvalCom_i             (r_vcom),
        .issueROBTagExec_i            (r_texec),
        .issueROBvalExec_i            (r_vexec),
        .issueROBMemAccessExec_i      (r_memacc),
        .issueROBTagMem_i             (r_tmem),
        .issueROBvalMem_i             (r_vmem),
        .stall_i                      (r_stall_i),
        .reservationStationVal1_o     (w_v1),
        .reservationStationVal2_o     (w_v2),
        .reservationStationCommands_o (w_cmd),
        .reservationStationTag_o      (w_tag),
        .ready_o                      (w_ready)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [TW-1:0]    dst;
        logic [CMD_W-1:0] cmd;
        logic [TW-1:0]    t1, t2;
        logic [DATA_W:0]  o1, o2;
    } ent_t;

    typedef struct {
        logic [DATA_W-1:0] v1, v2;
        logic [CMD_W-1:0]  cmd;
        logic [TW-1:0]     tag;
    } iss_t;

    ent_t m_q[$];     // waiting ops, oldest first
    iss_t exp_q[$];   // predicted issues
    bit   exp_ready = 1'b0;
    bit   exp_stall = 1'b0;
    bit   chk_en    = 1'b0;
    int   n_cmp     = 0;
    int   n_fail    = 0;

    function automatic logic [DATA_W:0] fwd(input logic [DATA_W:0] cur, input logic [TW-1:0] tag);
        if (cur[DATA_W]) return cur;
        if (r_vexec[DATA_W] && !r_memacc && r_texec == tag) return r_vexec;
        if (r_vmem[DATA_W] && r_tmem == tag) return r_vmem;
        if (r_vcom[DATA_W] && r_tcom == tag) return r_vcom;
        return cur;
    endfunction

    // Predict this cycle's behaviour from the current inputs, then advance.
    task automatic model_eval();
        int   idx;
        ent_t e;
        iss_t s;
        chk_en = !r_reset;
        if (r_reset) begin
            m_q.delete();
            exp_ready = 1'b0;
            exp_stall = 1'b0;
            return;
        end
        exp_stall = (m_q.size() == ENTRIES);
        idx = -1;
        foreach (m_q[k]) if (idx < 0 && m_q[k].o1[DATA_W] && m_q[k].o2[DATA_W]) idx = k;
        exp_ready = (idx >= 0);
        if (exp_ready && !r_stall_i) begin
            s.v1  = m_q[idx].o1[DATA_W-1:0];
            s.v2  = m_q[idx].o2[DATA_W-1:0];
            s.cmd = m_q[idx].cmd;
            s.tag = m_q[idx].dst;
            exp_q.push_back(s);
            m_q.delete(idx);
        end
        foreach (m_q[k]) begin
            m_q[k].o1 = fwd(m_q[k].o1, m_q[k].t1);
            m_q[k].o2 = fwd(m_q[k].o2, m_q[k].t2);
        end
        if (r_we && !exp_stall) begin
            e.dst = r_dtag; e.cmd = r_dcmd; e.t1 = r_dt1; e.t2 = r_dt2;
            e.o1  = fwd(r_dv1, r_dt1);
            e.o2  = fwd(r_dv2, r_dt2);
            m_q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        iss_t s;
        if (chk_en) begin
            check("stall_o", 64'(w_stall_o), 64'(exp_stall));
            check("ready_o", 64'(w_ready), 64'(exp_ready));
            if (w_ready && !r_stall_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 64'(w_tag), 64'hffff_ffff_ffff_ffff);
                end else begin
                    s = exp_q.pop_front();
                    check("issue_tag",  64'(w_tag), 64'(s.tag));
                    check("issue_val1", w_v1, s.v1);
                    check("issue_val2", w_v2, s.v2);
                    check("issue_cmd",  64'(w_cmd), 64'(s.cmd));
                end
            end else if (!w_ready) begin
                check("idle_outputs_zero", w_v1 | w_v2 | 64'(w_cmd) | 64'(w_tag), 64'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle();
        r_we = 1'b0; r_dtag = '0; r_dt1 = '0; r_dt2 = '0;
        r_dv1 = '0; r_dv2 = '0; r_dcmd = '0;
        r_tcom = '0; r_texec = '0; r_tmem = '0;
        r_vcom = '0; r_vexec = '0; r_vmem = '0;
        r_memacc = 1'b0; r_stall_i = 1'b0;
    endtask

    task automatic alloc(input logic [TW-1:0] dst, input logic [TW-1:0] t1, input logic [DATA_W:0] v1,
                         input logic [TW-1:0] t2, input logic [DATA_W:0] v2);
        r_we = 1'b1; r_dtag = dst; r_dt1 = t1; r_dv1 = v1; r_dt2 = t2; r_dv2 = v2;
        r_dcmd = CMD_W'($urandom);
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        r_reset = 1'b1;
        step(); step();
        r_reset = 1'b0;
        step();

        // Four ready ops issue in allocation order.
        for (int k = 1; k <= 4; k++) begin
            idle(); alloc(TW'(3 * k), 0, {1'b1, rnd64()}, 0, {1'b1, rnd64()}); step();
        end
        idle(); repeat (3) step();

        // Five allocs waiting on tag 10: fifth is dropped, then release all.
        for (int k = 0; k < 5; k++) begin
            idle(); alloc(TW'(16 + k), 10, {1'b0, rnd64()}, 1, {1'b1, rnd64()}); step();
        end
        idle(); step();
        idle(); r_tcom = 10; r_vcom = {1'b1, rnd64()}; step();
        idle(); repeat (5) step();

        // Address result on exec bus is ignored; memory bus supplies operand.
        idle(); alloc(2, 5, {1'b0, rnd64()}, 0, {1'b1, rnd64()}); step();
        idle(); r_texec = 5; r_vexec = {1'b1, 64'h77}; r_memacc = 1'b1; step();
        idle(); r_tmem = 5; r_vmem = {1'b1, 64'hd0}; step();
        idle(); repeat (2) step();

        // Same-cycle forwarding at allocation.
        idle(); alloc(4, 7, {1'b0, rnd64()}, 0, {1'b1, rnd64()});
        r_texec = 7; r_vexec = {1'b1, 64'h42}; step();
        idle(); repeat (2) step();

        // Older waiting entry overtakes a younger ready one under stall_i.
        idle(); alloc(8, 20, {1'b0, rnd64()}, 0, {1'b1, rnd64()}); step();
        idle(); alloc(9, 0, {1'b1, rnd64()}, 0, {1'b1, rnd64()}); r_stall_i = 1'b1; step();
        idle(); r_stall_i = 1'b1; step();
        idle(); r_stall_i = 1'b1; r_tcom = 20; r_vcom = {1'b1, rnd64()}; step();
        idle(); r_stall_i = 1'b1; step();
        idle(); repeat (3) step();

        // Randomized traffic with a mid-run reset.
        for (int c = 0; c < 400; c++) begin
            r_reset   = (c == 200);
            r_we      = ($urandom_range(0, 9) < 6);
            r_dtag    = TW'($urandom_range(0, 31));
            r_dt1     = TW'($urandom_range(0, 7));
            r_dt2     = TW'($urandom_range(0, 7));
            r_dv1     = {($urandom_range(0, 1) == 1), rnd64()};
            r_dv2     = {($urandom_range(0, 1) == 1), rnd64()};
            r_dcmd    = CMD_W'($urandom);
            r_tcom    = TW'($urandom_range(0, 7));
            r_texec   = TW'($urandom_range(0, 7));
            r_tmem    = TW'($urandom_range(0, 7));
            r_vcom    = {($urandom_range(0, 2) == 0), rnd64()};
            r_vexec   = {($urandom_range(0, 2) == 0), rnd64()};
            r_vmem    = {($urandom_range(0, 2) == 0), rnd64()};
            r_memacc  = ($urandom_range(0, 3) == 0);
            r_stall_i = ($urandom_range(0, 9) < 3);
            step();
        end
        r_reset = 1'b0;
        idle(); repeat (4) step();

        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
